// File: rtl/muldiv_unit_pkg.sv
// -----------------------------------------------------------------------------
// muldiv_unit_pkg
//   Shared definitions for the HI/LO multiply/divide unit: the operation codes
//   presented by the execute stage and the control FSM state encoding.
// -----------------------------------------------------------------------------
package muldiv_unit_pkg;

    // Operation codes carried on muldiv_unit.op
    typedef enum logic [2:0] {
        MD_MULT  = 3'd0,
        MD_MULTU = 3'd1,
        MD_DIV   = 3'd2,
        MD_DIVU  = 3'd3,
        MD_MTHI  = 3'd4,
        MD_MTLO  = 3'd5
    } md_op_t;

    // Control FSM: IDLE -> RUN (ITER iterations) -> FINISH (sign fix, write) -> IDLE
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_FINISH = 2'd2
    } md_state_t;

endpackage

// File: rtl/muldiv_unit_step.sv
// -----------------------------------------------------------------------------
// muldiv_unit_step
//   One combinational iteration of the shared multiply/divide datapath.
//   The 2*WIDTH accumulator holds {upper, lower}:
//     multiply : {partial product, remaining multiplier bits}; add-then-shift-right
//     divide   : {partial remainder, dividend/quotient bits}; shift-left, trial subtract
//   Cascaded STEPS times by the top level.
// Ports
//   is_div   in   1         1 = restoring divide step, 0 = shift-add multiply step
//   opb      in   WIDTH     multiplicand (multiply) or divisor (divide), as magnitude
//   acc_in   in   2*WIDTH   accumulator before this step
//   acc_out  out  2*WIDTH   accumulator after this step
// -----------------------------------------------------------------------------
module muldiv_unit_step #(
    parameter int WIDTH = 32
) (
    input  logic               is_div,
    input  logic [WIDTH-1:0]   opb,
    input  logic [2*WIDTH-1:0] acc_in,
    output logic [2*WIDTH-1:0] acc_out
);

    logic [WIDTH:0] mul_sum;
    logic [WIDTH:0] trial;
    logic [WIDTH:0] div_diff;

    // NOTE: every signal written here gets a value before any branch, so no
    // path leaves one unassigned and no latch is inferred.
    always_comb begin
        acc_out  = acc_in;
        mul_sum  = '0;
        trial    = '0;
        div_diff = '0;
        if (is_div) begin
            // Partial remainder shifted left with the next dividend bit; it can
            // reach 2*divisor-1, hence the extra bit. The top bit of the
            // difference is the borrow (trial < divisor).
            trial    = {acc_in[2*WIDTH-1:WIDTH], acc_in[WIDTH-1]};
            div_diff = trial - {1'b0, opb};
            if (!div_diff[WIDTH]) begin
                acc_out = {div_diff[WIDTH-1:0], acc_in[WIDTH-2:0], 1'b1};
            end else begin
                acc_out = {trial[WIDTH-1:0], acc_in[WIDTH-2:0], 1'b0};
            end
        end else begin
            // Add the multiplicand when the current multiplier LSB is set, then
            // shift the whole accumulator right; the carry becomes the new MSB.
            mul_sum = {1'b0, acc_in[2*WIDTH-1:WIDTH]} + (acc_in[0] ? {1'b0, opb} : '0);
            acc_out = {mul_sum, acc_in[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// -----------------------------------------------------------------------------
// muldiv_unit
//   Multi-cycle HI/LO unit for the execute stage. Executes MULT/MULTU with an
//   iterative shift-add multiplier and DIV/DIVU with a restoring divider, both
//   sharing one 2*WIDTH accumulator; MTHI/MTLO write HI/LO directly. The
//   execute stage stalls on busy and reads HI/LO straight from the outputs.
// Parameters
//   WIDTH  operand width (HI and LO are WIDTH bits each)
//   STEPS  iteration steps per clock (1 or 2), must divide WIDTH
// Ports
//   CLK    in   1      clock, rising edge
//   RST    in   1      asynchronous active-low reset
//   abort  in   1      (only with MULDIV_ABORT_EN) cancel the running operation
//   start  in   1      request strobe, accepted only when busy==0
//   op     in   3      operation code (muldiv_unit_pkg::md_op_t)
//   rs     in   WIDTH  multiplicand / dividend / MTHI-MTLO source
//   rt     in   WIDTH  multiplier / divisor
//   busy   out  1      iterative operation in progress
//   done   out  1      one-cycle pulse: HI/LO updated or request retired
//   HI     out  WIDTH  product upper half / remainder
//   LO     out  WIDTH  product lower half / quotient
// Configuration
//   MULDIV_ABORT_EN  defined: adds the abort port; abort while busy returns to
//                    IDLE without writing HI/LO and without a done pulse.
//                    undefined: every accepted operation runs to completion.
// -----------------------------------------------------------------------------
module muldiv_unit
    import muldiv_unit_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int STEPS = 1
) (
    input  logic             CLK,
    input  logic             RST,
`ifdef MULDIV_ABORT_EN
    input  logic             abort,
`endif
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] rs,
    input  logic [WIDTH-1:0] rt,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO
);

    localparam int ITER  = WIDTH / STEPS;
    localparam int CNT_W = $clog2(ITER + 1);

    md_state_t          state, state_next;
    logic [CNT_W-1:0]   cnt;
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]   opb;
    logic               is_div;
    logic               neg_res;   // negate product (mul) or quotient (div)
    logic               neg_rem;   // negate remainder (signed div only)
    logic [WIDTH-1:0]   hi_q, lo_q;
    logic               done_q;
    logic               abort_req;

`ifdef MULDIV_ABORT_EN
    assign abort_req = abort;
`else
    assign abort_req = 1'b0;
`endif

    // ---------------- request decode ----------------
    md_op_t           op_e;
    logic             is_mul_op, is_div_op, is_signed_op, div_zero;
    logic             sign_a, sign_b, accept, launch;
    logic [WIDTH-1:0] mag_a, mag_b;

    assign op_e         = md_op_t'(op);
    assign is_mul_op    = (op_e == MD_MULT) || (op_e == MD_MULTU);
    assign is_div_op    = (op_e == MD_DIV)  || (op_e == MD_DIVU);
    assign is_signed_op = (op_e == MD_MULT) || (op_e == MD_DIV);
    assign div_zero     = is_div_op && (rt == '0);
    assign sign_a       = is_signed_op && rs[WIDTH-1];
    assign sign_b       = is_signed_op && rt[WIDTH-1];
    // |most-negative| wraps to itself, which is the correct unsigned magnitude.
    assign mag_a        = sign_a ? -rs : rs;
    assign mag_b        = sign_b ? -rt : rt;
    // Start wins over abort in IDLE: abort only acts on a running operation.
    assign accept       = start && (state == ST_IDLE);
    assign launch       = accept && (is_mul_op || (is_div_op && !div_zero));

    // ---------------- iteration datapath ----------------
    logic [2*WIDTH-1:0] chain [STEPS+1];

    assign chain[0] = acc;

    for (genvar g = 0; g < STEPS; g++) begin : g_step
        muldiv_unit_step #(.WIDTH(WIDTH)) u_step (
            .is_div (is_div),
            .opb    (opb),
            .acc_in (chain[g]),
            .acc_out(chain[g+1])
        );
    end

    // Sign fix applied once, at FINISH, to the magnitude result.
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   quot, rem, fin_hi, fin_lo;

    assign prod   = neg_res ? -acc : acc;
    assign quot   = neg_res ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    assign rem    = neg_rem ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
    assign fin_hi = is_div ? rem  : prod[2*WIDTH-1:WIDTH];
    assign fin_lo = is_div ? quot : prod[WIDTH-1:0];

    // ---------------- control FSM ----------------
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        busy       = (state != ST_IDLE);
        unique case (state)
            ST_IDLE:   if (launch) state_next = ST_RUN;
            ST_RUN: begin
                if (abort_req)                         state_next = ST_IDLE;
                else if (cnt == CNT_W'(ITER - 1))      state_next = ST_FINISH;
            end
            ST_FINISH: state_next = ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
    end

    // ---------------- operand, counter and HI/LO registers ----------------
    // NOTE: the datapath registers are reset along with the control state, so
    // a reset in the middle of an operation leaves nothing stale behind.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            cnt     <= '0;
            acc     <= '0;
            opb     <= '0;
            is_div  <= 1'b0;
            neg_res <= 1'b0;
            neg_rem <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
            done_q  <= 1'b0;
        end else begin
            // NOTE: state registers use non-blocking assignment so every
            // right-hand side sees pre-edge values regardless of statement order.
            done_q <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (accept) begin
                        case (op_e)
                            MD_MTHI: begin
                                hi_q   <= rs;
                                done_q <= 1'b1;
                            end
                            MD_MTLO: begin
                                lo_q   <= rs;
                                done_q <= 1'b1;
                            end
                            MD_MULT, MD_MULTU: begin
                                acc     <= {{WIDTH{1'b0}}, mag_b};
                                opb     <= mag_a;
                                is_div  <= 1'b0;
                                neg_res <= sign_a ^ sign_b;
                                neg_rem <= 1'b0;
                                cnt     <= '0;
                            end
                            MD_DIV, MD_DIVU: begin
                                if (div_zero) begin
                                    // Retire immediately, HI/LO untouched.
                                    done_q <= 1'b1;
                                end else begin
                                    acc     <= {{WIDTH{1'b0}}, mag_a};
                                    opb     <= mag_b;
                                    is_div  <= 1'b1;
                                    neg_res <= sign_a ^ sign_b;
                                    neg_rem <= sign_a;
                                    cnt     <= '0;
                                end
                            end
                            default: ;
                        endcase
                    end
                end
                ST_RUN: begin
                    if (!abort_req) begin
                        acc <= chain[STEPS];
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_FINISH: begin
                    if (!abort_req) begin
                        hi_q   <= fin_hi;
                        lo_q   <= fin_lo;
                        done_q <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign done = done_q;
    assign HI   = hi_q;
    assign LO   = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// -----------------------------------------------------------------------------
// tb_muldiv_unit
//   Directed-vector bench for muldiv_unit (WIDTH=32, STEPS=1). Stimulus pushes
//   the hand-computed {HI,LO} into a queue; a monitor pops and compares on
//   every done pulse. Abort vectors are included when MULDIV_ABORT_EN is set.
// -----------------------------------------------------------------------------
module tb_muldiv_unit;
    import muldiv_unit_pkg::*;

    localparam int W     = 32;
    localparam int STEPS = 1;
    localparam int ITER  = W / STEPS;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [2:0]   op;
    logic [W-1:0] rs, rt;
    logic         busy, done;
    logic [W-1:0] hi, lo;
`ifdef MULDIV_ABORT_EN
    logic         abort;
`endif

    always #5 clk = ~clk;

    muldiv_unit #(.WIDTH(W), .STEPS(STEPS)) dut (
        .CLK  (clk),
        .RST  (rst),
`ifdef MULDIV_ABORT_EN
        .abort(abort),
`endif
        .start(start),
        .op   (op),
        .rs   (rs),
        .rt   (rt),
        .busy (busy),
        .done (done),
        .HI   (hi),
        .LO   (lo)
    );

    typedef struct {
        string          name;
        logic [2*W-1:0] val;
    } exp_t;

    exp_t exp_q[$];
    int   tests  = 0;
    int   failed = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        tests++;
        if (act !== req) begin
            failed++;
            $display("FAIL %s: got 0x%0h, wanted 0x%0h", name, act, req);
        end
    endtask

    task automatic push(input string name, input logic [2*W-1:0] val);
        exp_t e;
        e.name = name;
        e.val  = val;
        exp_q.push_back(e);
    endtask

    // Drop strobes and scramble operands: nothing after the accept edge may matter.
    task automatic clear_inputs();
        start = 1'b0;
`ifdef MULDIV_ABORT_EN
        abort = 1'b0;
`endif
        op = 3'($urandom_range(0, 5));
        rs = $urandom;
        rt = $urandom;
    endtask

    task automatic drive(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
        @(negedge clk);
        start = 1'b1;
        op    = o;
        rs    = a;
        rt    = b;
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) begin
            @(negedge clk);
            clear_inputs();
        end
    endtask

    // Called right after drive(); n counts edges from the accept edge up to
    // the cycle in which done is seen.
    task automatic wait_done(input string name, input int budget, output int n, output bit saw_busy);
        n        = 0;
        saw_busy = 1'b0;
        do begin
            @(negedge clk);
            n++;
            if (n == 1) clear_inputs();
            if (busy) saw_busy = 1'b1;
        end while (!done && n < budget);
        if (!done) begin
            tests++;
            failed++;
            $display("FAIL %s_timeout: no done within %0d cycles", name, budget);
        end
    endtask

    // Scoreboard monitor
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst === 1'b1 && done === 1'b1) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    failed++;
                    $display("FAIL unexpected_done: got done=1 with HI=0x%0h LO=0x%0h, wanted no done", hi, lo);
                end else begin
                    e = exp_q.pop_front();
                    check(e.name, {hi, lo}, e.val);
                    check({e.name, "_busy_with_done"}, 64'(busy), 64'd0);
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: summary not reached in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        bit sb;

        rst   = 1'b0;
        start = 1'b0;
        op    = '0;
        rs    = '0;
        rt    = '0;
`ifdef MULDIV_ABORT_EN
        abort = 1'b0;
`endif
        #1;
        check("rst_hi",   64'(hi),   64'd0);
        check("rst_lo",   64'(lo),   64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("post_rst_hi",   64'(hi),   64'd0);
        check("post_rst_busy", 64'(busy), 64'd0);

        // Unsigned max product and latency
        push("multu_max", 64'hFFFFFFFE_00000001);
        drive(MD_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF);
        wait_done("multu_max", 100, n, sb);
        check("multu_latency", 64'(n), 64'(ITER + 2));

        // Signed multiply / divide
        push("mult_neg", 64'hFFFFFFFF_FFFFFFEB);
        drive(MD_MULT, 32'hFFFFFFFD, 32'd7);
        wait_done("mult_neg", 100, n, sb);
        push("div_neg", 64'hFFFFFFFF_FFFFFFFD);
        drive(MD_DIV, 32'hFFFFFFF9, 32'd2);
        wait_done("div_neg", 100, n, sb);

        // Divide by zero: retired next cycle, HI/LO unchanged, never busy
        push("divu_zero", 64'hFFFFFFFF_FFFFFFFD);
        drive(MD_DIVU, 32'd100, 32'd0);
        wait_done("divu_zero", 5, n, sb);
        check("divu_zero_latency", 64'(n),  64'd1);
        check("divu_zero_busy",    64'(sb), 64'd0);

        // Signed overflow case
        push("div_ovf", 64'h00000000_80000000);
        drive(MD_DIV, 32'h80000000, 32'hFFFFFFFF);
        wait_done("div_ovf", 100, n, sb);

        // Further directed vectors
        push("divu_100_7", 64'h00000002_0000000E);
        drive(MD_DIVU, 32'd100, 32'd7);
        wait_done("divu_100_7", 100, n, sb);
        push("mult_m1_m1", 64'h00000000_00000001);
        drive(MD_MULT, 32'hFFFFFFFF, 32'hFFFFFFFF);
        wait_done("mult_m1_m1", 100, n, sb);
        push("div_7_m2", 64'h00000001_FFFFFFFD);
        drive(MD_DIV, 32'd7, 32'hFFFFFFFE);
        wait_done("div_7_m2", 100, n, sb);
        push("multu_shift", 64'h00000001_23456780);
        drive(MD_MULTU, 32'h12345678, 32'h00000010);
        wait_done("multu_shift", 100, n, sb);
        push("div_m8_m3", 64'hFFFFFFFE_00000002);
        drive(MD_DIV, 32'hFFFFFFF8, 32'hFFFFFFFD);
        wait_done("div_m8_m3", 100, n, sb);
        push("divu_max_1", 64'h00000000_FFFFFFFF);
        drive(MD_DIVU, 32'hFFFFFFFF, 32'd1);
        wait_done("divu_max_1", 100, n, sb);

        // MTHI then MTLO back-to-back
        push("mthi", 64'h00001234_FFFFFFFF);
        push("mtlo", 64'h00001234_00005678);
        drive(MD_MTHI, 32'h00001234, 32'd0);
        drive(MD_MTLO, 32'h00005678, 32'd0);
        check("mthi_done_next", 64'(done), 64'd1);
        wait_done("mtlo", 5, n, sb);
        check("mtlo_latency", 64'(n), 64'd1);

        // Start while busy is ignored
        push("multu_busy", 64'h00000000_0000001E);
        drive(MD_MULTU, 32'd5, 32'd6);
        idle_cycles(5);
        drive(MD_MTHI, 32'h0000DEAD, 32'd0);
        check("ignored_start_busy", 64'(busy), 64'd1);
        wait_done("multu_busy", 100, n, sb);
        idle_cycles(3);
        check("ignored_start_hi", 64'(hi), 64'd0);

        // Asynchronous reset in the middle of a divide
        drive(MD_DIVU, 32'd1000, 32'd3);
        idle_cycles(10);
        #2 rst = 1'b0;
        #1;
        check("midop_rst_hi",   64'(hi),   64'd0);
        check("midop_rst_lo",   64'(lo),   64'd0);
        check("midop_rst_busy", 64'(busy), 64'd0);
        idle_cycles(2);
        rst = 1'b1;
        push("multu_after_rst", 64'h00000000_0000000C);
        drive(MD_MULTU, 32'd3, 32'd4);
        wait_done("multu_after_rst", 100, n, sb);
        check("after_rst_latency", 64'(n), 64'(ITER + 2));

`ifdef MULDIV_ABORT_EN
        // Abort at cycle 10 of a multiply
        drive(MD_MULT, 32'd7, 32'd9);
        idle_cycles(9);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_done", 64'(done), 64'd0);
        idle_cycles(40);
        check("abort_hilo", {hi, lo}, 64'h00000000_0000000C);

        // Abort together with start in IDLE: start wins
        push("abort_start_idle", 64'h00000000_00000006);
        drive(MD_MULTU, 32'd2, 32'd3);
        abort = 1'b1;
        wait_done("abort_start_idle", 100, n, sb);
`endif

        idle_cycles(5);
        check("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
